// File: rtl/mem_arb_pkg.sv
// Shared state/grant encodings and default widths for the memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_MAX_D_STREAK = 4;

    // Arbiter transaction state: at most one memory access in flight.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    // Requester selected for the memory port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Fixed-priority grant select: data wins unless a waiting fetch has been starved.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the selection is accepted.
//
// Ports:
//   if_req      - fetch requester wants the port
//   d_req       - data requester wants the port
//   streak_full - data has already won the maximum run of grants against a pending fetch
//   gnt         - selected requester (GNT_NONE when nobody asks)
module mem_arb_priority
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic streak_full,
    output gnt_t gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (d_req && !(if_req && streak_full)) begin
            gnt = GNT_D;
        end else if (if_req) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters, one access in flight.
// Latency: request presented combinationally to memory; response forwarded combinationally, >=2 cycles req-to-resp.
// Backpressure: mem_gnt low holds mem_req/address/data; requesters see x_stall until their x_resp_valid pulse.
//
// Ports:
//   clk, reset                         - clock, synchronous active-high reset (forces all outputs to 0)
//   if_req/if_addr                     - fetch request, held until if_resp_valid
//   if_resp_valid/if_rdata/if_stall    - fetch response pulse, instruction word, stall
//   d_req/d_we/d_addr/d_wdata          - data request, held until d_resp_valid
//   d_resp_valid/d_rdata/d_stall       - data response pulse, load data (0 for writes), stall
//   mem_req/mem_we/mem_addr/mem_wdata  - memory command, accepted on mem_req & mem_gnt
//   mem_gnt                            - memory accepts the command
//   mem_resp_valid/mem_rdata           - memory response pulse and read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    state_t        state;
    state_t        state_n;
    gnt_t          gnt;
    logic [SW-1:0] d_streak;
    logic          streak_full;
    logic          i_hs;
    logic          d_hs;

    assign streak_full = (d_streak == SW'(MAX_D_STREAK));

    mem_arb_priority u_priority (
        .if_req      (if_req),
        .d_req       (d_req),
        .streak_full (streak_full),
        .gnt         (gnt)
    );

    // Handshakes only happen from IDLE; the WAIT states never drive mem_req.
    assign i_hs = (state == IDLE) && (gnt == GNT_I) && mem_gnt;
    assign d_hs = (state == IDLE) && (gnt == GNT_D) && mem_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            d_streak <= '0;
        end else begin
            state <= state_n;
            if (i_hs) begin
                d_streak <= '0;
            end else if (d_hs) begin
                // The streak only measures data wins against a fetch that is actually waiting.
                if (!if_req) begin
                    d_streak <= '0;
                end else if (!streak_full) begin
                    d_streak <= d_streak + SW'(1);
                end
            end
        end
    end

    always_comb begin
        state_n       = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if_resp_valid = 1'b0;
        if_rdata      = '0;
        d_resp_valid  = 1'b0;
        d_rdata       = '0;
        if_stall      = 1'b0;
        d_stall       = 1'b0;

        case (state)
            IDLE: begin
                // Responses arriving here are strays and are dropped.
                case (gnt)
                    GNT_D: begin
                        mem_req   = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        if (mem_gnt) state_n = WAIT_D;
                    end
                    GNT_I: begin
                        mem_req  = 1'b1;
                        mem_addr = if_addr;
                        if (mem_gnt) state_n = WAIT_I;
                    end
                    default: ;
                endcase
            end
            WAIT_I: begin
                if_resp_valid = mem_resp_valid;
                if (mem_resp_valid) begin
                    if_rdata = mem_rdata;
                    state_n  = IDLE;
                end
            end
            WAIT_D: begin
                d_resp_valid = mem_resp_valid;
                if (mem_resp_valid) begin
                    // d_we is still held by the requester, so it qualifies the load data here.
                    d_rdata = d_we ? '0 : mem_rdata;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (reset) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr      = '0;
            mem_wdata     = '0;
            if_resp_valid = 1'b0;
            if_rdata      = '0;
            d_resp_valid  = 1'b0;
            d_rdata       = '0;
        end else begin
            if_stall = if_req & ~if_resp_valid;
            d_stall  = d_req & ~d_resp_valid;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: arbitration table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_resp_valid;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_resp_valid;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .if_stall       (if_stall),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_rdata        (d_rdata),
        .d_stall        (d_stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    // Requester protocol: once raised, a request stays up until its response pulse.
    bit   hold_chk = 1'b0;
    logic if_live = 1'b0;
    logic d_live = 1'b0;
    always @(negedge clk) begin
        if (hold_chk && !reset) begin
            if (if_live && !if_req) $error("fetch request withdrawn before its response");
            if (d_live && !d_req)   $error("data request withdrawn before its response");
        end
        if_live <= if_req && !if_resp_valid && !reset;
        d_live  <= d_req && !d_resp_valid && !reset;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_all();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic [31:0] if_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_if_stall;
        logic        exp_d_stall;
    } vec_t;

    vec_t tbl[7];

    // Reference model state for the randomized phase.
    int          owner;      // 0 none, 1 fetch, 2 data
    int          streak;
    int          pick;
    logic [31:0] out_addr;
    logic        out_we;
    logic [31:0] rd_exp;
    bit          if_done;
    bit          d_done;
    logic        exp_ifv;
    logic        exp_dv;
    logic [31:0] mem_model [logic [31:0]];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h40,       32'h0,  32'h0,        1'b1, 1'b0, 32'h40,       32'h0,        1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h80, 32'h1234,     1'b1, 1'b0, 32'h80,       32'h1234,     1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h84, 32'hCAFEF00D, 1'b1, 1'b1, 32'h84,       32'hCAFEF00D, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h44,       32'h88, 32'h5,        1'b1, 1'b0, 32'h88,       32'h5,        1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h48,       32'h8C, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h8C,       32'hA5A5A5A5, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h90, 32'h77,       1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b0};

        // Reset state: every output is forced low even with live inputs.
        #1;
        reset = 1'b1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1;
        mem_gnt = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk1("rst if_stall", if_stall, 1'b0);
        chk1("rst d_stall", d_stall, 1'b0);
        chk1("rst if_resp_valid", if_resp_valid, 1'b0);
        chk1("rst d_resp_valid", d_resp_valid, 1'b0);
        chk32("rst d_rdata", d_rdata, 32'h0);
        cyc();
        do_reset();

        // Arbitration table in IDLE with mem_gnt low, so state and streak never move.
        foreach (tbl[i]) begin
            if_req = tbl[i].if_req; d_req = tbl[i].d_req; d_we = tbl[i].d_we;
            if_addr = tbl[i].if_addr; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            @(negedge clk);
            chk1 ($sformatf("tbl%0d mem_req", i),   mem_req,   tbl[i].exp_req);
            chk1 ($sformatf("tbl%0d mem_we", i),    mem_we,    tbl[i].exp_we);
            chk32($sformatf("tbl%0d mem_addr", i),  mem_addr,  tbl[i].exp_addr);
            chk32($sformatf("tbl%0d mem_wdata", i), mem_wdata, tbl[i].exp_wdata);
            chk1 ($sformatf("tbl%0d if_stall", i),  if_stall,  tbl[i].exp_if_stall);
            chk1 ($sformatf("tbl%0d d_stall", i),   d_stall,   tbl[i].exp_d_stall);
            cyc();
        end
        do_reset();
        hold_chk = 1'b1;

        // Single fetch, fastest response.
        if_req = 1'b1; if_addr = 32'h10; mem_gnt = 1'b1;
        @(negedge clk);
        chk1("s1 mem_req", mem_req, 1'b1);
        chk32("s1 mem_addr", mem_addr, 32'h10);
        chk1("s1 if_stall c0", if_stall, 1'b1);
        chk1("s1 if_resp_valid c0", if_resp_valid, 1'b0);
        cyc();
        mem_resp_valid = 1'b1; mem_rdata = 32'h00A00093;
        @(negedge clk);
        chk1("s1 if_resp_valid", if_resp_valid, 1'b1);
        chk32("s1 if_rdata", if_rdata, 32'h00A00093);
        chk1("s1 if_stall c1", if_stall, 1'b0);
        chk1("s1 mem_req in wait", mem_req, 1'b0);
        cyc();
        do_reset();

        // Simultaneous requests: data first, then fetch.
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; mem_gnt = 1'b1;
        @(negedge clk);
        chk32("s2 mem_addr D", mem_addr, 32'h100);
        chk1("s2 mem_we", mem_we, 1'b0);
        chk1("s2 if_stall", if_stall, 1'b1);
        chk1("s2 d_stall", d_stall, 1'b1);
        cyc();
        mem_resp_valid = 1'b1; mem_rdata = 32'h11223344;
        @(negedge clk);
        chk1("s2 d_resp_valid", d_resp_valid, 1'b1);
        chk32("s2 d_rdata", d_rdata, 32'h11223344);
        chk1("s2 if_resp_valid", if_resp_valid, 1'b0);
        chk1("s2 if_stall held", if_stall, 1'b1);
        chk1("s2 d_stall done", d_stall, 1'b0);
        cyc();
        mem_resp_valid = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk1("s2 mem_req I", mem_req, 1'b1);
        chk32("s2 mem_addr I", mem_addr, 32'h10);
        cyc();
        mem_resp_valid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        chk1("s2 if_resp_valid I", if_resp_valid, 1'b1);
        chk32("s2 if_rdata", if_rdata, 32'h55);
        cyc();
        do_reset();

        // Anti-starvation: four data grants, then the fetch, then data again.
        if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; mem_gnt = 1'b1;
        for (int g = 0; g < 7; g++) begin
            if (g == 6) d_req = 1'b0;
            @(negedge clk);
            chk1($sformatf("s3 g%0d mem_req", g), mem_req, 1'b1);
            chk32($sformatf("s3 g%0d mem_addr", g), mem_addr, (g == 4 || g == 6) ? 32'h1000 : 32'h2000);
            cyc();
            mem_resp_valid = 1'b1; mem_rdata = 32'(g);
            @(negedge clk);
            chk1($sformatf("s3 g%0d if_resp_valid", g), if_resp_valid, (g == 4 || g == 6));
            chk1($sformatf("s3 g%0d d_resp_valid", g), d_resp_valid, !(g == 4 || g == 6));
            cyc();
            mem_resp_valid = 1'b0;
        end
        do_reset();

        // Write held under memory backpressure.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            mem_gnt = (k == 3);
            @(negedge clk);
            chk1($sformatf("s4 k%0d mem_req", k), mem_req, 1'b1);
            chk1($sformatf("s4 k%0d mem_we", k), mem_we, 1'b1);
            chk32($sformatf("s4 k%0d mem_addr", k), mem_addr, 32'h200);
            chk32($sformatf("s4 k%0d mem_wdata", k), mem_wdata, 32'hDEADBEEF);
            chk1($sformatf("s4 k%0d d_stall", k), d_stall, 1'b1);
            cyc();
        end
        mem_gnt = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk1("s4 d_resp_valid", d_resp_valid, 1'b1);
        chk32("s4 d_rdata write", d_rdata, 32'h0);
        chk1("s4 d_stall done", d_stall, 1'b0);
        chk1("s4 mem_req in wait", mem_req, 1'b0);
        cyc();
        do_reset();

        // Reset while a data read is outstanding.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_gnt = 1'b1;
        @(negedge clk);
        chk1("s5 mem_req issue", mem_req, 1'b1);
        cyc();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk1("s5 mem_req wait", mem_req, 1'b0);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk1("s5 rst mem_req", mem_req, 1'b0);
        chk1("s5 rst d_stall", d_stall, 1'b0);
        chk1("s5 rst d_resp_valid", d_resp_valid, 1'b0);
        cyc();
        reset = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk1("s5 reissue mem_req", mem_req, 1'b1);
        chk32("s5 reissue mem_addr", mem_addr, 32'h300);
        chk1("s5 reissue d_stall", d_stall, 1'b1);
        chk1("s5 no stale resp", d_resp_valid, 1'b0);
        cyc();
        mem_gnt = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        chk1("s5 d_resp_valid", d_resp_valid, 1'b1);
        chk32("s5 d_rdata", d_rdata, 32'h77);
        cyc();
        do_reset();

        // Stray response in IDLE is ignored and leaves the arbiter idle.
        mem_resp_valid = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        chk1("s6 if_resp_valid", if_resp_valid, 1'b0);
        chk1("s6 d_resp_valid", d_resp_valid, 1'b0);
        cyc();
        mem_resp_valid = 1'b0; if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        chk1("s6 still idle mem_req", mem_req, 1'b1);
        chk32("s6 mem_addr", mem_addr, 32'h20);
        cyc();
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1;
        @(negedge clk);
        chk1("s6 if_resp_valid", if_resp_valid, 1'b1);
        chk32("s6 if_rdata", if_rdata, 32'h1);
        cyc();
        do_reset();

        // Randomized traffic against the transaction-level model.
        owner = 0; streak = 0; if_done = 1'b0; d_done = 1'b0;
        out_addr = '0; out_we = 1'b0; rd_exp = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || if_done) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_req || d_done) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
            mem_gnt = ($urandom_range(0, 3) != 0);
            if (owner != 0) begin
                mem_resp_valid = 1'($urandom_range(0, 1));
                rd_exp = mem_model.exists(out_addr) ? mem_model[out_addr] : ~out_addr;
                mem_rdata = out_we ? $urandom : rd_exp;
            end else begin
                mem_resp_valid = ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end

            @(negedge clk);
            exp_ifv = (owner == 1) && mem_resp_valid;
            exp_dv  = (owner == 2) && mem_resp_valid;
            chk1("rnd if_resp_valid", if_resp_valid, exp_ifv);
            chk1("rnd d_resp_valid", d_resp_valid, exp_dv);
            chk1("rnd if_stall", if_stall, if_req && !exp_ifv);
            chk1("rnd d_stall", d_stall, d_req && !exp_dv);
            if (exp_ifv) chk32("rnd if_rdata", if_rdata, rd_exp);
            if (exp_dv)  chk32("rnd d_rdata", d_rdata, out_we ? 32'h0 : rd_exp);
            if (owner == 0) begin
                if (d_req && !(if_req && streak == MAXS)) pick = 2;
                else if (if_req)                         pick = 1;
                else                                     pick = 0;
                chk1("rnd mem_req", mem_req, pick != 0);
                if (pick == 2) begin
                    chk32("rnd mem_addr D", mem_addr, d_addr);
                    chk1("rnd mem_we D", mem_we, d_we);
                    chk32("rnd mem_wdata D", mem_wdata, d_wdata);
                end else if (pick == 1) begin
                    chk32("rnd mem_addr I", mem_addr, if_addr);
                    chk1("rnd mem_we I", mem_we, 1'b0);
                    chk32("rnd mem_wdata I", mem_wdata, 32'h0);
                end
                if (pick != 0 && mem_gnt) begin
                    owner = pick;
                    if (pick == 2) begin
                        out_addr = d_addr;
                        out_we   = d_we;
                        if (d_we) mem_model[d_addr] = d_wdata;
                        streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    end else begin
                        out_addr = if_addr;
                        out_we   = 1'b0;
                        streak   = 0;
                    end
                end
            end else begin
                chk1("rnd mem_req busy", mem_req, 1'b0);
                if (mem_resp_valid) owner = 0;
            end
            if_done = exp_ifv;
            d_done  = exp_dv;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
